// File: rtl/method_call_arbiter_if.sv
// ---------------------------------------------------------------------------
// method_call_arbiter_if
// Client-side and method-side signals of method_call_arbiter, bundled.
//   cli_req     client -> arb   level request per client, held until cli_done
//   cli_busy    arb -> client   request pending or call in service
//   cli_done    arb -> client   one-cycle result-valid pulse
//   cli_return  arb -> client   per-client result, slot i at [i*RET_W +: RET_W]
//   m_req       arb -> method   call request
//   m_busy      method -> arb   method busy
//   m_return    method -> arb   return value, valid once m_busy falls
//   grant_id    arb -> obs      client currently in service
//   active      arb -> obs      arbiter not idle
//   timeout_err arb -> obs      sticky watchdog flag
// slave modport: arbiter side.  master modport: clients + method side.
// ---------------------------------------------------------------------------
interface method_call_arbiter_if #(
  parameter int N_CLIENTS = 4,
  parameter int RET_W     = 32
);
  logic [N_CLIENTS-1:0]       cli_req;
  logic [N_CLIENTS-1:0]       cli_busy;
  logic [N_CLIENTS-1:0]       cli_done;
  logic [N_CLIENTS*RET_W-1:0] cli_return;
  logic                       m_req;
  logic                       m_busy;
  logic [RET_W-1:0]           m_return;
  logic [2:0]                 grant_id;
  logic                       active;
  logic                       timeout_err;

  modport slave (
    input  cli_req, m_busy, m_return,
    output cli_busy, cli_done, cli_return, m_req, grant_id, active, timeout_err
  );
  modport master (
    output cli_req, m_busy, m_return,
    input  cli_busy, cli_done, cli_return, m_req, grant_id, active, timeout_err
  );
endinterface

// File: rtl/method_call_arbiter.sv
// ---------------------------------------------------------------------------
// method_call_arbiter
// Round-robin sharing of one method instance (req/busy/return handshake)
// among N_CLIENTS callers. One call in flight; the return value is latched
// into the winner's slot and a one-cycle done strobe is pulsed.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    method_call_arbiter_if.slave (client + method handshake)
// Optional: define ARB_WATCHDOG_EN to build the per-call watchdog
// (WD_LIMIT cycles); without it timeout_err is constant 0.
// ---------------------------------------------------------------------------

// Per-client lane: result slot, done strobe, busy indication.
module method_call_arbiter_lane #(
  parameter int RET_W = 32
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cap,
  input  logic             i_req,
  input  logic             i_sel,
  input  logic [RET_W-1:0] i_ret,
  output logic             o_done,
  output logic             o_busy,
  output logic [RET_W-1:0] o_ret
);
  logic             r_done;
  logic [RET_W-1:0] r_ret;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
      r_ret  <= '0;
    end else begin
      r_done <= i_cap;
      if (i_cap) r_ret <= i_ret;
    end
  end

  assign o_done = r_done;
  assign o_ret  = r_ret;
  assign o_busy = i_req | i_sel;
endmodule

module method_call_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int RET_W     = 32,
  parameter int WD_LIMIT  = 10000
)(
  input logic                  clk,
  input logic                  reset,
  method_call_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_CAPTURE
  } state_t;

  state_t                              r_state, w_next;
  logic [2:0]                          r_grant, r_rr_ptr, w_pick, w_ptr_nxt;
  logic                                w_found, w_m_req, w_active, w_wd_hit;
  logic [N_CLIENTS-1:0]                w_done, w_busy, w_cap;
  logic [7:0]                          w_req_pad;
  logic [RET_W-1:0]                    w_cap_ret;
  logic [N_CLIENTS-1:0][RET_W-1:0]     w_slot;

  // Unsupported configurations elaborate an empty marker block.
  if (N_CLIENTS < 2 || N_CLIENTS > 8 || WD_LIMIT < 1) begin : g_cfg_unsupported
  end

  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_CLIENTS) s = s - N_CLIENTS;
    return 3'(s);
  endfunction

  // A client in its done-pulse cycle is masked so a held request counts
  // as a new call that queues behind everyone else.
  assign w_req_pad = 8'(bus.cli_req & ~w_done);

  // Scan downward so the last hit is the closest one at/after rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int k = N_CLIENTS-1; k >= 0; k--) begin
      if (w_req_pad[wrap_idx(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_pick  = wrap_idx(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_m_req = 1'b0;
    unique case (r_state)
      S_IDLE:      if (w_found) w_next = S_ISSUE;
      S_ISSUE:     begin w_m_req = 1'b1; w_next = S_WAIT_BUSY; end
      S_WAIT_BUSY: begin
        w_m_req = 1'b1;
        if (w_wd_hit)         w_next = S_CAPTURE;
        else if (bus.m_busy)  w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (w_wd_hit || !bus.m_busy) w_next = S_CAPTURE;
      S_CAPTURE:   w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  assign w_ptr_nxt = (r_grant == 3'(N_CLIENTS-1)) ? 3'd0 : r_grant + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_found) r_grant  <= w_pick;
      if (r_state == S_CAPTURE)         r_rr_ptr <= w_ptr_nxt;
    end
  end

`ifdef ARB_WATCHDOG_EN
  logic [31:0] r_wd_cnt;
  logic        r_to_call, r_timeout_err, w_in_wait;

  assign w_in_wait = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
  assign w_wd_hit  = w_in_wait && (r_wd_cnt == 32'(WD_LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd_cnt      <= '0;
      r_to_call     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (r_state == S_IDLE && w_found) begin
      r_wd_cnt  <= '0;
      r_to_call <= 1'b0;
    end else if (w_wd_hit) begin
      r_to_call     <= 1'b1;
      r_timeout_err <= 1'b1;
    end else if (w_in_wait) begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
    end
  end

  // A timed-out call delivers zero instead of whatever the method shows.
  assign w_cap_ret       = r_to_call ? '0 : bus.m_return;
  assign bus.timeout_err = r_timeout_err;
`else
  assign w_wd_hit        = 1'b0;
  assign w_cap_ret       = bus.m_return;
  assign bus.timeout_err = 1'b0;
`endif

  assign w_active = (r_state != S_IDLE);

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_lane
    assign w_cap[i] = (r_state == S_CAPTURE) && (r_grant == 3'(i));
    method_call_arbiter_lane #(.RET_W(RET_W)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_cap  (w_cap[i]),
      .i_req  (bus.cli_req[i]),
      .i_sel  (w_active && (r_grant == 3'(i))),
      .i_ret  (w_cap_ret),
      .o_done (w_done[i]),
      .o_busy (w_busy[i]),
      .o_ret  (w_slot[i])
    );
  end

  assign bus.cli_busy   = w_busy;
  assign bus.cli_done   = w_done;
  assign bus.cli_return = w_slot;
  assign bus.m_req      = w_m_req;
  assign bus.grant_id   = r_grant;
  assign bus.active     = w_active;
endmodule

// File: tb/tb_method_call_arbiter.sv
module tb_method_call_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int WDL = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  method_call_arbiter_if #(.N_CLIENTS(N), .RET_W(W)) bus ();

  method_call_arbiter #(.N_CLIENTS(N), .RET_W(W), .WD_LIMIT(WDL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- method model ----------------
  int          m_lat;
  bit          m_stuck;
  int          ret_mode;   // 0 fixed, 1 base+call#, 2 random value + random latency
  logic [31:0] ret_fixed, ret_base;
  logic [31:0] ret_log [0:255];
  int          mcalls;
  int          rem;
  logic [31:0] mv;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.m_busy   <= 1'b0;
      bus.m_return <= '0;
      rem    = 0;
      mcalls = 0;
    end else if (bus.m_busy) begin
      if (!m_stuck) begin
        if (rem <= 1) bus.m_busy <= 1'b0;
        rem = rem - 1;
      end
    end else if (bus.m_req) begin
      case (ret_mode)
        0:       mv = ret_fixed;
        1:       mv = ret_base + 32'(mcalls);
        default: mv = $urandom;
      endcase
      rem = (ret_mode == 2) ? int'($urandom_range(1, 6)) : m_lat;
      ret_log[mcalls[7:0]] = mv;
      mcalls = mcalls + 1;
      bus.m_busy   <= 1'b1;
      bus.m_return <= mv;
    end
  end

  // m_req pulse counter (rising edges)
  int   mreq_pulses = 0;
  logic mreq_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.m_req && !mreq_prev) mreq_pulses++;
    mreq_prev = bus.m_req;
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    reset = 1'b0;
    bus.cli_req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Counts posedges from the current negedge until a done strobe is seen.
  task automatic wait_done(input int budget, output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    while (idx < 0 && cyc < budget) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int b = N-1; b >= 0; b--) if (bus.cli_done[b]) idx = b;
    end
  endtask

  task automatic wait_in_done_wait(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.active && bus.m_busy && !bus.m_req) ok = 1'b1;
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++) if (p[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  typedef struct {
    int          cli;
    int          lat;
    logic [31:0] ret;
    int          exp_lat;
  } vec_t;

  vec_t        vt [5];
  int          idx, cyc, p0, ptr, pred, c, rd;
  bit          ok;
  int          order2 [4];
  int          order3 [4];
  logic [N-1:0]   pend;
  logic [127:0]   exp_slots;

  initial begin
    vt[0] = '{0, 5,  32'h0000_002A, 9};
    vt[1] = '{1, 1,  32'h0000_0001, 5};
    vt[2] = '{3, 3,  32'hDEAD_BEEF, 7};
    vt[3] = '{2, 10, 32'hFFFF_FFFF, 14};
    vt[4] = '{0, 2,  32'h0000_0000, 6};
    order2 = '{0, 1, 2, 3};
    order3 = '{0, 2, 0, 2};

    reset = 1'b0; bus.cli_req = '0;
    m_stuck = 0; ret_mode = 0; m_lat = 1; ret_fixed = '0; ret_base = '0;
    repeat (2) @(negedge clk);
    check("reset_ctl", {bus.m_req, bus.active, bus.timeout_err, bus.grant_id,
                        bus.cli_done, bus.cli_busy}, '0);
    check("reset_slots", bus.cli_return, '0);
    reset = 1'b1;
    @(negedge clk);

    // ---- single calls from the vector table ----
    for (int i = 0; i < 5; i++) begin
      ret_mode = 0; ret_fixed = vt[i].ret; m_lat = vt[i].lat;
      p0 = mreq_pulses;
      bus.cli_req = '0;
      bus.cli_req[vt[i].cli] = 1'b1;
      wait_done(40, idx, cyc);
      bus.cli_req = '0;
      check($sformatf("vec%0d_done_idx", i), idx, vt[i].cli);
      check($sformatf("vec%0d_latency", i), cyc, vt[i].exp_lat);
      check($sformatf("vec%0d_slot", i), bus.cli_return[vt[i].cli*W +: W], vt[i].ret);
      check($sformatf("vec%0d_grant_id", i), bus.grant_id, vt[i].cli);
      check($sformatf("vec%0d_mreq_pulses", i), mreq_pulses - p0, 1);
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), {bus.cli_done, bus.active}, '0);
    end

    // ---- all-request contention ----
    do_reset();
    ret_mode = 1; ret_base = 32'h10; m_lat = 3;
    p0 = mreq_pulses;
    bus.cli_req = 4'hF;
    for (int g = 0; g < 4; g++) begin
      wait_done(40, idx, cyc);
      check($sformatf("contend_order%0d", g), idx, order2[g]);
      if (idx >= 0) bus.cli_req[idx] = 1'b0;
    end
    check("contend_mreq_pulses", mreq_pulses - p0, 4);
    check("contend_slots", bus.cli_return,
          {32'h13, 32'h12, 32'h11, 32'h10});

    // ---- fairness: client 2 held, client 0 re-requests ----
    do_reset();
    ret_mode = 0; ret_fixed = 32'h55; m_lat = 2;
    bus.cli_req = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      wait_done(40, idx, cyc);
      check($sformatf("fair_order%0d", g), idx, order3[g]);
      if (g == 3) bus.cli_req = '0;
      else if (idx == 0) begin
        bus.cli_req[0] = 1'b0;
        @(negedge clk);
        bus.cli_req[0] = 1'b1;
      end
    end

    // ---- reset mid-call ----
    ret_fixed = 32'h77; m_lat = 8;
    bus.cli_req = 4'b1000;
    wait_in_done_wait(10, ok);
    check("rstmid_reached_wait_done", ok, 1);
    reset = 1'b0;
    #1;
    check("rstmid_ctl", {bus.m_req, bus.active, bus.cli_done, bus.grant_id}, '0);
    check("rstmid_slots", bus.cli_return, '0);
    bus.cli_req = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ret_fixed = 32'h99; m_lat = 2;
    bus.cli_req = 4'b0010;
    wait_done(40, idx, cyc);
    bus.cli_req = '0;
    check("rstmid_after_idx", idx, 1);
    check("rstmid_after_lat", cyc, 6);
    check("rstmid_after_slots", bus.cli_return, {32'h0, 32'h0, 32'h99, 32'h0});

    // ---- request dropped mid-call ----
    ret_fixed = 32'hCAFE; m_lat = 6;
    bus.cli_req = 4'b1000;
    wait_in_done_wait(10, ok);
    check("drop_reached_wait_done", ok, 1);
    bus.cli_req = '0;
    #1;
    check("drop_busy_held", bus.cli_busy, 4'b1000);
    wait_done(40, idx, cyc);
    check("drop_done_idx", idx, 3);
    check("drop_slots", bus.cli_return, {32'hCAFE, 32'h0, 32'h99, 32'h0});

    // ---- stuck method ----
    do_reset();
    m_stuck = 1; m_lat = 1; ret_fixed = 32'h1234;
    bus.cli_req = 4'b0001;
    wait_done(60, idx, cyc);
    bus.cli_req = '0;
`ifdef ARB_WATCHDOG_EN
    check("wd_done_idx", idx, 0);
    check("wd_latency_window", (cyc >= WDL && cyc <= WDL + 6), 1);
    check("wd_slot_zero", bus.cli_return[W-1:0], '0);
    check("wd_timeout_err", bus.timeout_err, 1);
    repeat (3) @(negedge clk);
    check("wd_timeout_sticky", bus.timeout_err, 1);
`else
    check("nowd_no_done", idx, -1);
    check("nowd_active_held", bus.active, 1);
    check("nowd_timeout_err", bus.timeout_err, 0);
`endif
    m_stuck = 0;

    // ---- randomized traffic vs round-robin reference ----
    do_reset();
    ret_mode = 2; ptr = 0; rd = 0; exp_slots = '0;
    pend = 4'($urandom_range(1, 15));
    bus.cli_req = pend;
    for (int t = 0; t < 40; t++) begin
      pred = rr_pick(pend, ptr);
      wait_done(40, idx, cyc);
      check($sformatf("rnd%0d_grant", t), idx, pred);
      c = (idx >= 0) ? idx : pred;
      exp_slots[c*W +: W] = ret_log[rd[7:0]];
      rd++;
      check($sformatf("rnd%0d_slots", t), bus.cli_return, exp_slots);
      ptr = (c + 1) % N;
      pend[c] = 1'b0;
      pend = pend | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      if (pend == '0) pend[$urandom_range(0, N-1)] = 1'b1;
      bus.cli_req = pend;
    end
    bus.cli_req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
